stream_turbo_block_framer: RTL and testbench

Upstream feeder for the streaming turbo decoder. It accepts channel LLRs one value per cycle under a valid/ready handshake and assembles them into per-symbol lane vectors. It buffers a complete code block in a two-bank ping-pong store. It then releases each block as an uninterrupted burst of SYMBOLS cycles on the decoder's `in_valid`/`y` port, because the decoder's interleaver and delay line require contiguous blocks and apply no backpressure.

---
 rtl/turbo_pkg.sv | 17 +
 rtl/sdp_ram.sv | 23 ++
 rtl/stream_turbo_block_framer.sv | 156 +++++++++++++++
 tb/tb_stream_turbo_block_framer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo decoder front end.
package turbo_pkg;

  localparam int DEF_BITS = 16;
  localparam int DEF_NOUT = 2;

  function automatic int lanes(input int nout);
    return 1 + 2 * (nout - 1);
  endfunction

  localparam int DEF_LANES = lanes(DEF_NOUT);

  typedef logic [DEF_LANES-1:0][DEF_BITS-1:0] llr_vec_t;

  typedef enum logic [1:0] {IDLE, BURST, GAP} rd_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write and one registered read per cycle.
// Storage is deliberately not reset; consumers gate the read data themselves.
module sdp_ram #(
  parameter int AW    = 7,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_turbo_block_framer.sv
// Packs LLRs into lane vectors, buffers whole blocks in a ping-pong store and
// replays each as a contiguous SYMBOLS-cycle burst, 2 cycles after block commit.
module stream_turbo_block_framer
  import turbo_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int N         = 64,
  parameter int NOUT      = 2,
  parameter int TAIL_BITS = 0,
  parameter int GAP       = 0
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BITS-1:0]                    in_llr,
  input  logic                               in_last,
  output logic                               out_valid,
  output logic [lanes(NOUT)-1:0][BITS-1:0]   y,
  output logic                               frame_err
);

  localparam int LANES   = lanes(NOUT);
  localparam int SYMBOLS = N + TAIL_BITS;
  localparam int SW      = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GW      = 8;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(SYMBOLS - 1);

  typedef logic [LANES-1:0][BITS-1:0] vec_t;

  logic [LW-1:0]                lane_cnt;
  logic [SW-1:0]                sym_cnt;
  logic                         wr_bank;
  logic                         rd_bank;
  logic [1:0]                   bank_full;
  logic [LANES-2:0][BITS-1:0]   asm_q;
  vec_t                         wr_vec;
  vec_t                         rd_vec;
  logic                         accept;
  logic                         lane_end;
  logic                         blk_end;
  logic                         commit;
  logic                         early;
  rd_state_t                    state;
  rd_state_t                    state_nxt;
  logic [SW-1:0]                rd_addr;
  logic [GW-1:0]                gap_cnt;
  logic                         rd_issue;
  logic                         rd_done;

  assign in_ready = !bank_full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign lane_end = (lane_cnt == LANE_LAST);
  assign blk_end  = lane_end && (sym_cnt == SYM_LAST);
  assign commit   = accept && blk_end;
  assign early    = accept && in_last && !blk_end;

  always_comb begin
    wr_vec = '0;
    for (int l = 0; l < LANES - 1; l++) wr_vec[l] = asm_q[l];
    wr_vec[LANES-1] = in_llr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_cnt  <= '0;
      sym_cnt   <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
      asm_q     <= '0;
    end else if (accept) begin
      for (int l = 0; l < LANES - 1; l++)
        if (!lane_end && lane_cnt == LW'(l)) asm_q[l] <= in_llr;
      if (early || blk_end) begin
        lane_cnt <= '0;
        sym_cnt  <= '0;
      end else if (lane_end) begin
        lane_cnt <= '0;
        sym_cnt  <= sym_cnt + SW'(1);
      end else begin
        lane_cnt <= lane_cnt + LW'(1);
      end
      if (commit) wr_bank <= !wr_bank;
      // a complete block is kept even without in_last, but still flagged
      if (early || (commit && !in_last)) frame_err <= 1'b1;
    end
  end

  // commit and release always target different banks, so both may land on one edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full <= '0;
      rd_bank   <= 1'b0;
    end else begin
      if (commit) bank_full[wr_bank] <= 1'b1;
      if (rd_done) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= !rd_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      rd_addr <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= (state == BURST && !rd_done) ? rd_addr + SW'(1) : '0;
      gap_cnt <= (state == turbo_pkg::GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  // with no gap, chain straight into the other bank so bursts stay seamless
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bank_full[rd_bank]) state_nxt = BURST;
      BURST: if (rd_done) begin
        if (GAP > 0)                  state_nxt = turbo_pkg::GAP;
        else if (!bank_full[!rd_bank]) state_nxt = IDLE;
      end
      turbo_pkg::GAP: if (gap_cnt == GW'(GAP - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state == BURST);
    rd_done  = rd_issue && (rd_addr == SYM_LAST);
  end

  sdp_ram #(
    .AW    (SW + 1),
    .WIDTH (LANES * BITS)
  ) u_ram (
    .clk   (clk),
    .we    (accept && lane_end),
    .waddr ({wr_bank, sym_cnt}),
    .wdata (wr_vec),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_vec)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_valid <= 1'b0;
    else       out_valid <= rd_issue;
  end

  assign y = out_valid ? rd_vec : '0;

endmodule

// File: tb/tb_stream_turbo_block_framer.sv
// Scoreboarded bench: two framer instances (GAP=0 and GAP=200) driven with
// random and indexed LLR streams, checked against a block-level reference model.
module tb_stream_turbo_block_framer;
  import turbo_pkg::*;

  localparam int BITS    = 16;
  localparam int LANES   = 3;
  localparam int SYMBOLS = 64;
  localparam int BLK     = LANES * SYMBOLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", g, nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int TGAP = (g == 0) ? 0 : 200;
    // output-edge distance from the end of one burst to the start of the next
    localparam int DLY  = (TGAP > 0) ? TGAP + 2 : 1;

    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic            out_valid;
    logic            frame_err;
    logic [BITS-1:0] in_llr;
    llr_vec_t        y;
    bit              done_g = 1'b0;

    stream_turbo_block_framer #(.GAP(TGAP)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_llr    (in_llr),
      .in_last   (in_last),
      .out_valid (out_valid),
      .y         (y),
      .frame_err (frame_err)
    );

    logic [BITS-1:0] pend[$];
    llr_vec_t        exp_q[$];
    int              exp_start[$];
    int              committed;
    int              finished;
    int              last_start;
    int              sym_idx;
    bit              exp_err;

    task automatic model_clear();
      pend.delete();
      exp_q.delete();
      exp_start.delete();
      committed  = 0;
      finished   = 0;
      last_start = -100000;
      sym_idx    = 0;
      exp_err    = 1'b0;
    endtask

    // reference model: collect accepted LLRs, emit a block once BLK have arrived
    always @(posedge clk) begin
      if (rstn === 1'b1 && in_valid && in_ready) begin
        pend.push_back(in_llr);
        if (pend.size() == BLK) begin
          llr_vec_t v;
          int st;
          for (int s = 0; s < SYMBOLS; s++) begin
            for (int l = 0; l < LANES; l++) v[l] = pend[s * LANES + l];
            exp_q.push_back(v);
          end
          st = (cyc + 2 > last_start + SYMBOLS - 1 + DLY) ? cyc + 2 : last_start + SYMBOLS - 1 + DLY;
          exp_start.push_back(st);
          last_start = st;
          committed++;
          if (!in_last) exp_err = 1'b1;
          pend.delete();
        end else if (in_last) begin
          pend.delete();
          exp_err = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (rstn === 1'b1) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL inst%0d unexpected out_valid: got 1 expected 0 (t=%0t)", g, $time);
          end else begin
            if (sym_idx == 0) chk("burst start edge", g, cyc - 1, exp_start.pop_front());
            chk("y data", g, y, exp_q.pop_front());
            sym_idx++;
            if (sym_idx == SYMBOLS) begin
              sym_idx = 0;
              finished++;
            end
          end
        end else begin
          chk("y zero when idle", g, y, 0);
          chk("burst contiguous", g, sym_idx, 0);
          sym_idx = 0;
        end
        // writer may only stall while both banks hold undelivered blocks
        chk("in_ready", g, in_ready, (committed - finished) < 2);
        chk("frame_err", g, frame_err, exp_err);
      end
    end

    task automatic send(input logic [BITS-1:0] v, input logic l, input int idle_max);
      int t = 0;
      bit acc = 1'b0;
      if (idle_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(idle_max, 0)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_llr   = v;
      in_last  = l;
      do begin
        acc = in_ready;
        @(negedge clk);
        t++;
      end while (!acc && t < 2000);
      chk("llr accepted", g, acc, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
    endtask

    // kind 0: clean block, 1: in_last on LLR 100, 2: no in_last at all
    task automatic send_block(input int kind, input bit rnd, input int idle_max);
      int n = (kind == 1) ? 101 : BLK;
      for (int i = 0; i < n; i++)
        send(rnd ? BITS'($urandom) : BITS'(i),
             (kind == 1) ? (i == 100) : (kind == 0 && i == n - 1), idle_max);
    endtask

    task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      repeat (5) @(negedge clk);
      chk("all expected output seen", g, exp_q.size(), 0);
    endtask

    task automatic do_reset();
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_clear();
      #1;
      chk("reset out_valid", g, out_valid, 0);
      chk("reset y", g, y, 0);
      chk("reset in_ready", g, in_ready, 1);
      chk("reset frame_err", g, frame_err, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
    endtask

    initial begin
      int t;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_llr   = '0;
      do_reset();

      send_block(0, 1'b0, 0);
      drain();

      repeat (4) send_block(0, 1'b1, 0);
      drain();

      send_block(1, 1'b1, 2);
      send_block(0, 1'b1, 2);
      drain();
      chk("frame_err after early in_last", g, frame_err, 1);

      do_reset();
      send_block(2, 1'b1, 1);
      drain();
      chk("frame_err after missing in_last", g, frame_err, 1);

      do_reset();
      send_block(0, 1'b1, 0);
      t = 0;
      while (sym_idx != 10 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      chk("reached burst cycle 10", g, sym_idx, 10);
      do_reset();
      send_block(0, 1'b1, 1);
      drain();
      chk("frame_err clean after reset", g, frame_err, 0);

      done_g = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(inst[0].done_g && inst[1].done_g) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    chk("all scenarios finished", 0, inst[0].done_g && inst[1].done_g, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
